bsr_block_scheduler: RTL and testbench

- Sequences `systolic_array_sparse` over a block-sparse (BSR) weight matrix.
- Walks `row_ptr`/`col_idx` metadata, one block row at a time, and skips empty block rows entirely.
- For each non-zero block it drives the row-by-row weight load, the activation stream with `block_valid`, and a pipeline drain.
- Pulses `row_done` when a block row's accumulators are final.
- Sits between the CSR/DMA front end and the array, act_buffer and wgt_buffer.

---
 rtl/bsr_sched_pkg.sv | 13 +
 rtl/sched_phase_counter.sv | 21 ++
 rtl/bsr_block_scheduler.sv | 155 +++++++++++++++
 tb/tb_bsr_block_scheduler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsr_sched_pkg.sv
// bsr_sched_pkg: state encoding, default phase lengths and buffer address helper for the BSR scheduler
package bsr_sched_pkg;
  typedef enum logic [3:0] {
    IDLE, RP0, RP1, RPW, CI, CIW, LOADW, COMP, DRAIN, ROWEND, FIN
  } sched_state_e;
  localparam int LOADW_CYC = 16;
  localparam int COMP_CYC  = 16;
  localparam int DRAIN_CYC = 16;
  function automatic logic [31:0] blk_addr(input logic [31:0] blk, input logic [31:0] size,
                                           input logic [31:0] idx);
    return blk * size + idx;
  endfunction
endpackage

// File: rtl/sched_phase_counter.sv
// sched_phase_counter: loadable down-counter timing the LOADW/COMP/DRAIN phases
module sched_phase_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? load_val : (hold || last) ? cnt_q : cnt_q - W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt  = cnt_q;
  assign last = cnt_q == '0;
endmodule

// File: rtl/bsr_block_scheduler.sv
// bsr_block_scheduler: walks BSR row_ptr/col_idx metadata and sequences weight load, compute and drain per block
module bsr_block_scheduler import bsr_sched_pkg::*; #(
  parameter int N_ROWS  = LOADW_CYC,
  parameter int N_COLS  = DRAIN_CYC,
  parameter int K_TILE  = COMP_CYC,
  parameter int META_AW = 10,
  parameter int BLK_W   = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BLK_W-1:0]   num_brows,
  input  logic               hold,
  output logic               rp_rd_en,
  output logic [META_AW-1:0] rp_rd_addr,
  input  logic [BLK_W-1:0]   rp_rd_data,
  output logic               ci_rd_en,
  output logic [META_AW-1:0] ci_rd_addr,
  input  logic [BLK_W-1:0]   ci_rd_data,
  output logic               wgt_rd_en,
  output logic [ADDR_W-1:0]  wgt_rd_addr,
  output logic               act_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  output logic               act_zero,
  output logic               load_weight,
  output logic               block_valid,
  output logic               row_done,
  output logic [BLK_W-1:0]   row_idx,
  output logic               busy,
  output logic               done
);
  localparam int M1   = N_ROWS > K_TILE ? N_ROWS : K_TILE;
  localparam int MAXC = M1 > N_COLS ? M1 : N_COLS;
  localparam int CW   = $clog2(MAXC + 1);

  sched_state_e     state_q, state_d;
  logic [BLK_W-1:0] nb_q, nb_d, br_q, br_d, p_q, p_d, e_q, e_d, bc_q, bc_d, e_cur;
  logic [BLK_W:0]   p_inc;
  logic             rp_v_q, ci_v_q, load_weight_q, block_valid_q, act_zero_q;
  logic             run, drain_en, cnt_load, last;
  logic [CW-1:0]    cnt, load_val;
  logic [31:0]      row_i, k_i;

  sched_phase_counter #(.W(CW)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (load_val),
    .hold     (hold),
    .cnt      (cnt),
    .last     (last)
  );

  // Enables are gated by hold in the same cycle so a frozen counter never re-issues or skips a read.
  assign run         = !hold;
  assign row_i       = 32'(N_ROWS - 1) - 32'(cnt);
  assign k_i         = 32'(K_TILE - 1) - 32'(cnt);
  assign rp_rd_en    = run && (state_q == RP0 || state_q == RP1);
  assign rp_rd_addr  = rp_rd_en ? META_AW'(state_q == RP1 ? br_q + 1'b1 : br_q) : '0;
  assign ci_rd_en    = run && state_q == CI;
  assign ci_rd_addr  = ci_rd_en ? META_AW'(p_q) : '0;
  assign wgt_rd_en   = run && state_q == LOADW;
  assign wgt_rd_addr = wgt_rd_en ? ADDR_W'(blk_addr(32'(p_q), N_ROWS, row_i)) : '0;
  assign act_rd_en   = run && state_q == COMP;
  assign act_rd_addr = act_rd_en ? ADDR_W'(blk_addr(32'(bc_q), K_TILE, k_i)) : '0;
  assign drain_en    = run && state_q == DRAIN;
  assign act_zero    = act_zero_q;
  assign load_weight = load_weight_q;
  assign block_valid = block_valid_q;
  assign row_done    = run && state_q == ROWEND;
  assign row_idx     = br_q;
  assign done        = run && state_q == FIN;
  assign busy        = state_q != IDLE && state_q != FIN;
  // Read data is captured on the cycle it arrives, even if hold is up, so a stall never loses it.
  assign e_cur       = (state_q == RPW && rp_v_q) ? rp_rd_data : e_q;
  assign p_inc       = {1'b0, p_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    nb_d     = nb_q;
    br_d     = br_q;
    p_d      = (state_q == RP1 && rp_v_q) ? rp_rd_data : p_q;
    e_d      = e_cur;
    bc_d     = (state_q == CIW && ci_v_q) ? ci_rd_data : bc_q;
    cnt_load = 1'b0;
    load_val = '0;
    if (run) begin
      case (state_q)
        IDLE: if (start) begin
          nb_d    = num_brows;
          br_d    = '0;
          state_d = num_brows == '0 ? FIN : RP0;
        end
        RP0:    state_d = RP1;
        RP1:    state_d = RPW;
        RPW:    state_d = e_cur <= p_q ? ROWEND : CI;
        CI:     state_d = CIW;
        CIW: begin
          state_d  = LOADW;
          cnt_load = 1'b1;
          load_val = CW'(N_ROWS - 1);
        end
        LOADW: if (last) begin
          state_d  = COMP;
          cnt_load = 1'b1;
          load_val = CW'(K_TILE - 1);
        end
        COMP: if (last) begin
          state_d  = DRAIN;
          cnt_load = 1'b1;
          load_val = CW'(N_COLS - 1);
        end
        DRAIN: if (last) begin
          p_d     = p_inc[BLK_W-1:0];
          state_d = p_inc < {1'b0, e_q} ? CI : ROWEND;
        end
        ROWEND: begin
          br_d    = br_q + 1'b1;
          state_d = br_q + 1'b1 == nb_q ? FIN : RP0;
        end
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      nb_q          <= '0;
      br_q          <= '0;
      p_q           <= '0;
      e_q           <= '0;
      bc_q          <= '0;
      rp_v_q        <= 1'b0;
      ci_v_q        <= 1'b0;
      load_weight_q <= 1'b0;
      block_valid_q <= 1'b0;
      act_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      nb_q          <= nb_d;
      br_q          <= br_d;
      p_q           <= p_d;
      e_q           <= e_d;
      bc_q          <= bc_d;
      rp_v_q        <= rp_rd_en;
      ci_v_q        <= ci_rd_en;
      load_weight_q <= wgt_rd_en;
      block_valid_q <= act_rd_en || drain_en;
      act_zero_q    <= drain_en;
    end
  end
endmodule

// File: tb/tb_bsr_block_scheduler.sv
// tb_bsr_block_scheduler: directed table plus randomized passes checked against a metadata-walking reference model
module tb_bsr_block_scheduler;
  localparam int NR = 4;
  localparam int KT = 4;
  localparam int NC = 4;

  logic        clk, rst_n, start, hold;
  logic [15:0] num_brows;
  logic        rp_rd_en, ci_rd_en, wgt_rd_en, act_rd_en;
  logic [9:0]  rp_rd_addr, ci_rd_addr;
  logic [15:0] rp_rd_data, ci_rd_data, wgt_rd_addr, act_rd_addr, row_idx;
  logic        act_zero, load_weight, block_valid, row_done, busy, done;

  logic [15:0] rp_mem [0:1023];
  logic [15:0] ci_mem [0:1023];

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    int nb;
    int rp0, rp1, rp2, rp3, rp4;
    int ci0, ci1, ci2;
    int hold_at, hold_len, restart_at;
    int lat, lw, bv, rows;
  } vec_t;

  bsr_block_scheduler #(
    .N_ROWS(NR), .N_COLS(NC), .K_TILE(KT), .META_AW(10), .BLK_W(16), .ADDR_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_brows   (num_brows),
    .hold        (hold),
    .rp_rd_en    (rp_rd_en),
    .rp_rd_addr  (rp_rd_addr),
    .rp_rd_data  (rp_rd_data),
    .ci_rd_en    (ci_rd_en),
    .ci_rd_addr  (ci_rd_addr),
    .ci_rd_data  (ci_rd_data),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_rd_addr (wgt_rd_addr),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .act_zero    (act_zero),
    .load_weight (load_weight),
    .block_valid (block_valid),
    .row_done    (row_done),
    .row_idx     (row_idx),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rp_rd_en) rp_rd_data <= rp_mem[rp_rd_addr];
    if (ci_rd_en) ci_rd_data <= ci_mem[ci_rd_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input int a[$], input int e[$]);
    int bad = -1;
    int n = a.size() > e.size() ? a.size() : e.size();
    for (int i = 0; i < n && bad < 0; i++)
      if (i >= a.size() || i >= e.size() || a[i] != e[i]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: item %0d got %0d (len %0d) expected %0d (len %0d)", name, bad,
               bad < a.size() ? a[bad] : -99, a.size(), bad < e.size() ? e[bad] : -99, e.size());
    end
  endtask

  function automatic int outs_nonzero();
    return int'(|{rp_rd_en, rp_rd_addr, ci_rd_en, ci_rd_addr, wgt_rd_en, wgt_rd_addr, act_rd_en,
                  act_rd_addr, act_zero, load_weight, block_valid, row_done, row_idx, busy, done});
  endfunction

  // One pass: model expectations from memory contents, drive start/hold, observe every cycle.
  task automatic run_pass(input int nb, input int hold_at, input int hold_len, input int restart_at,
                          input bit rnd_hold, input int t_lat, input int t_lw, input int t_bv, input int t_rows);
    int exp_lw[$], exp_bv[$], exp_rows[$], obs_lw[$], obs_bv[$], obs_rows[$];
    int blocks = 0, base_lat = 1, lat = -1, hold_n = 0, inv_err = 0, busy_err = 0;
    int rp_n = 0, ci_n = 0, extra = 0, prev_w = -5, prev_a = -5;
    bit prev_h = 1'b0;
    for (int br = 0; br < nb; br++) begin
      int p = int'(rp_mem[br]);
      int e = int'(rp_mem[br+1]);
      base_lat += 4;
      for (int q = p; q < e; q++) begin
        int col = int'(ci_mem[q % 1024]);
        blocks++;
        base_lat += 2 + NR + KT + NC;
        for (int r = 0; r < NR; r++) exp_lw.push_back((q * NR + r) & 'hFFFF);
        for (int k = 0; k < KT; k++) exp_bv.push_back((col * KT + k) & 'hFFFF);
        for (int c = 0; c < NC; c++) exp_bv.push_back(-1);
      end
      exp_rows.push_back(br);
    end
    @(posedge clk); #1;
    start = 1'b1;
    num_brows = 16'(nb);
    hold = 1'b0;
    @(negedge clk);
    if (busy) busy_err++;
    for (int cyc = 1; cyc <= 3000 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      start = cyc == restart_at;
      hold = (cyc >= hold_at && cyc < hold_at + hold_len) || (rnd_hold && $urandom_range(0, 7) == 0);
      @(negedge clk);
      if (hold) hold_n++;
      if (load_weight) obs_lw.push_back(prev_w);
      if (block_valid) obs_bv.push_back(act_zero ? (prev_a == -5 ? -1 : -3) : prev_a);
      if ((load_weight && block_valid) || (act_zero && !block_valid)) inv_err++;
      if (prev_h && (load_weight || block_valid)) inv_err++;
      if (row_done) obs_rows.push_back(int'(row_idx));
      if (rp_rd_en) rp_n++;
      if (ci_rd_en) ci_n++;
      if (!hold && busy != (nb != 0 && !done)) busy_err++;
      prev_w = wgt_rd_en ? int'(wgt_rd_addr) : -5;
      prev_a = act_rd_en ? int'(act_rd_addr) : -5;
      prev_h = hold;
      if (done) lat = cyc;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold = 1'b0;
      @(negedge clk);
      if (done || row_done || busy || rp_rd_en || ci_rd_en || load_weight || block_valid) extra++;
    end
    chk("latency", lat, base_lat + hold_n);
    chk_q("wgt_rows", obs_lw, exp_lw);
    chk_q("act_stream", obs_bv, exp_bv);
    chk_q("row_done_idx", obs_rows, exp_rows);
    chk("rp_reads", rp_n, 2 * nb);
    chk("ci_reads", ci_n, blocks);
    chk("invariants", inv_err, 0);
    chk("busy", busy_err, 0);
    chk("quiet_after_done", extra, 0);
    if (t_lat >= 0) begin
      chk("tbl_latency", lat, t_lat);
      chk("tbl_load_weight_cycles", obs_lw.size(), t_lw);
      chk("tbl_block_valid_cycles", obs_bv.size(), t_bv);
      chk("tbl_row_done_count", obs_rows.size(), t_rows);
    end
  endtask

  task automatic load_vec(input vec_t v);
    rp_mem[0] = 16'(v.rp0);
    rp_mem[1] = 16'(v.rp1);
    rp_mem[2] = 16'(v.rp2);
    rp_mem[3] = 16'(v.rp3);
    rp_mem[4] = 16'(v.rp4);
    ci_mem[0] = 16'(v.ci0);
    ci_mem[1] = 16'(v.ci1);
    ci_mem[2] = 16'(v.ci2);
  endtask

  initial begin
    vec_t tbl [6];
    int found = 0;
    tbl[0] = '{1, 0, 1, 0, 0, 0, 2, 0, 0, -1, 0, -1, 19, 4, 8, 1};
    tbl[1] = '{3, 0, 2, 2, 3, 0, 0, 3, 1, -1, 0, -1, 55, 12, 24, 3};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, -1, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 1, 0, 0, 0, 2, 0, 0, 7, 3, -1, 22, 4, 8, 1};
    tbl[4] = '{1, 5, 3, 0, 0, 0, 0, 0, 0, -1, 0, 2, 5, 0, 0, 1};
    tbl[5] = '{1, 16384, 16385, 0, 0, 0, 16385, 0, 0, -1, 0, -1, 19, 4, 8, 1};
    rst_n = 1'b0;
    start = 1'b0;
    hold = 1'b0;
    num_brows = '0;
    for (int i = 0; i < 1024; i++) begin
      rp_mem[i] = '0;
      ci_mem[i] = '0;
    end
    #1;
    chk("reset_outputs", outs_nonzero(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs_nonzero(), 0);

    for (int i = 0; i < 6; i++) begin
      load_vec(tbl[i]);
      run_pass(tbl[i].nb, tbl[i].hold_at, tbl[i].hold_len, tbl[i].restart_at, 1'b0,
               tbl[i].lat, tbl[i].lw, tbl[i].bv, tbl[i].rows);
    end

    // Asynchronous reset in the middle of COMP, then a clean rerun from block row 0.
    load_vec(tbl[0]);
    @(posedge clk); #1;
    start = 1'b1;
    num_brows = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (act_rd_en) found = 1;
    end
    chk("reached_comp", found, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_comp", outs_nonzero(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_pass(1, -1, 0, -1, 1'b0, 19, 4, 8, 1);

    for (int t = 0; t < 24; t++) begin
      int nb = $urandom_range(0, 4);
      for (int i = 0; i < 5; i++) rp_mem[i] = 16'($urandom_range(0, 6));
      for (int i = 0; i < 8; i++) ci_mem[i] = 16'($urandom_range(0, 15));
      run_pass(nb, -1, 0, -1, 1'b1, -1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
